// File: rtl/down_counter_timer_pkg.sv
// Shared definitions for the down counter timer: FSM encodings used by the counter family.
package down_counter_timer_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/down_counter_timer.sv
// Loadable down-counter / interval timer with a one-cycle terminal-count pulse
// and optional periodic reload. Priority per edge: clear > load > en.
module down_counter_timer
  import down_counter_timer_pkg::*;
#(
  parameter int unsigned bits = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clear,
  input  logic            load,
  input  logic [bits-1:0] load_val,
  input  logic            en,
  input  logic            auto_reload,
  output logic [bits-1:0] Q,
  output logic            tc,
  output logic            busy
);

  localparam logic [bits-1:0] ZERO = '0;
  localparam logic [bits-1:0] ONE  = {{(bits-1){1'b0}}, 1'b1};

  logic [0:0]      r_state;
  logic [bits-1:0] r_q;
  logic [bits-1:0] r_reload;
  logic            r_tc;

  logic [0:0]      w_next_state;
  logic [bits-1:0] w_next_q;
  logic [bits-1:0] w_next_reload;
  logic            w_next_tc;

  always_comb begin
    w_next_state  = r_state;
    w_next_q      = r_q;
    w_next_reload = r_reload;
    w_next_tc     = 1'b0;
    if (clear) begin
      w_next_q     = ZERO;
      w_next_state = ST_IDLE;
    end else if (load) begin
      if (load_val != ZERO) begin
        w_next_q      = load_val;
        w_next_reload = load_val;
        w_next_state  = ST_RUN;
      end else begin
        w_next_q     = ZERO;
        w_next_state = ST_IDLE;
      end
    end else if (r_state == ST_RUN && en) begin
      if (r_q == ONE) begin
        // auto_reload only matters on the terminal edge
        w_next_tc = 1'b1;
        if (auto_reload) begin
          w_next_q = r_reload;
        end else begin
          w_next_q     = ZERO;
          w_next_state = ST_IDLE;
        end
      end else if (r_q == ZERO) begin
        w_next_state = ST_IDLE;
      end else begin
        w_next_q = r_q - ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_q      <= ZERO;
      r_reload <= ZERO;
      r_tc     <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_q      <= w_next_q;
      r_reload <= w_next_reload;
      r_tc     <= w_next_tc;
    end
  end

  // busy is the FSM state itself, so it doubles as the state observation point
  assign Q    = r_q;
  assign tc   = r_tc;
  assign busy = (r_state == ST_RUN);

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed bench for down_counter_timer (bits=4): reset, one-shot, periodic,
// enable gating at max value, collisions and async reset mid-count.
module tb_down_counter_timer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         clear;
  logic         load;
  logic [W-1:0] load_val;
  logic         en;
  logic         auto_reload;
  logic [W-1:0] Q;
  logic         tc;
  logic         busy;

  int n_checks = 0;
  int n_pass   = 0;

  down_counter_timer #(.bits(W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (clear),
    .load        (load),
    .load_val    (load_val),
    .en          (en),
    .auto_reload (auto_reload),
    .Q           (Q),
    .tc          (tc),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Inputs change at negedge; one edge passes, outputs are sampled at the next negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; clear = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; auto_reload = 1'b0;
    #1;
    n_checks++;
    if ({Q, tc, busy} !== {4'd0, 1'b0, 1'b0})
      $display("FAIL reset_hold: Q=%0d tc=%0b busy=%0b, need Q=0 tc=0 busy=0", Q, tc, busy);
    else n_pass++;
    #1 reset_n = 1'b1;
    @(negedge clk);
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({Q, tc, busy} !== {4'd0, 1'b0, 1'b0})
        $display("FAIL reset_en_no_load[%0d]: Q=%0d tc=%0b busy=%0b, need 0/0/0", i, Q, tc, busy);
      else n_pass++;
    end
    en = 1'b0;
  endtask

  task automatic test_one_shot();
    logic [W-1:0] exp_q [0:6];
    logic         exp_tc [0:6];
    logic         exp_busy [0:6];
    exp_q    = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd0};
    exp_tc   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    load = 1'b1; load_val = 4'd5; en = 1'b1; auto_reload = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      load = 1'b0;
      n_checks++;
      if ({Q, tc, busy} !== {exp_q[i], exp_tc[i], exp_busy[i]})
        $display("FAIL one_shot[%0d]: Q=%0d tc=%0b busy=%0b, need Q=%0d tc=%0b busy=%0b",
                 i, Q, tc, busy, exp_q[i], exp_tc[i], exp_busy[i]);
      else n_pass++;
    end
    en = 1'b0;
  endtask

  task automatic test_periodic();
    logic [W-1:0] exp_q [0:9];
    logic         exp_tc [0:9];
    exp_q  = '{4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3, 4'd2};
    exp_tc = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    load = 1'b1; load_val = 4'd3; auto_reload = 1'b1; en = 1'b0;
    step();
    load = 1'b0;
    n_checks++;
    if ({Q, tc, busy} !== {4'd3, 1'b0, 1'b1})
      $display("FAIL periodic_load: Q=%0d tc=%0b busy=%0b, need Q=3 tc=0 busy=1", Q, tc, busy);
    else n_pass++;
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if ({Q, tc, busy} !== {exp_q[i], exp_tc[i], 1'b1})
        $display("FAIL periodic[%0d]: Q=%0d tc=%0b busy=%0b, need Q=%0d tc=%0b busy=1",
                 i, Q, tc, busy, exp_q[i], exp_tc[i]);
      else n_pass++;
    end
    en = 1'b0; auto_reload = 1'b0;
  endtask

  task automatic test_enable_gating_max();
    int en_count = 0;
    int tc_count = 0;
    logic [W-1:0] want_q;
    logic         want_tc;
    load = 1'b1; load_val = 4'd15; en = 1'b0; auto_reload = 1'b0;
    step();
    load = 1'b0;
    n_checks++;
    if ({Q, busy} !== {4'd15, 1'b1})
      $display("FAIL max_load: Q=%0d busy=%0b, need Q=15 busy=1", Q, busy);
    else n_pass++;
    for (int i = 0; i < 32; i++) begin
      en = (i % 2 == 0);
      if (en && en_count < 15) en_count++;
      step();
      want_q  = 4'(15 - en_count);
      want_tc = en && (en_count == 15) && (i == 28);
      if (tc) tc_count++;
      n_checks++;
      if ({Q, tc} !== {want_q, want_tc})
        $display("FAIL en_gating[%0d]: Q=%0d tc=%0b, need Q=%0d tc=%0b", i, Q, tc, want_q, want_tc);
      else n_pass++;
    end
    n_checks++;
    if (tc_count !== 1)
      $display("FAIL en_gating_tc_count: got %0d pulses, need 1", tc_count);
    else n_pass++;
    en = 1'b0;
  endtask

  task automatic test_collisions();
    // load + clear on the same edge
    load = 1'b1; load_val = 4'd7; en = 1'b1;
    step();
    clear = 1'b1; load = 1'b1; load_val = 4'd9;
    step();
    clear = 1'b0; load = 1'b0;
    n_checks++;
    if ({Q, tc, busy} !== {4'd0, 1'b0, 1'b0})
      $display("FAIL load_clear: Q=%0d tc=%0b busy=%0b, need 0/0/0", Q, tc, busy);
    else n_pass++;
    // load 9 on the terminal edge
    load = 1'b1; load_val = 4'd2;
    step();
    load = 1'b0;
    step();
    n_checks++;
    if ({Q, busy} !== {4'd1, 1'b1})
      $display("FAIL pre_terminal: Q=%0d busy=%0b, need Q=1 busy=1", Q, busy);
    else n_pass++;
    load = 1'b1; load_val = 4'd9;
    step();
    load = 1'b0;
    n_checks++;
    if ({Q, tc, busy} !== {4'd9, 1'b0, 1'b1})
      $display("FAIL load_on_terminal: Q=%0d tc=%0b busy=%0b, need Q=9 tc=0 busy=1", Q, tc, busy);
    else n_pass++;
    // clear on the terminal edge
    load = 1'b1; load_val = 4'd1;
    step();
    load = 1'b0; clear = 1'b1;
    step();
    clear = 1'b0;
    n_checks++;
    if ({Q, tc, busy} !== {4'd0, 1'b0, 1'b0})
      $display("FAIL clear_on_terminal: Q=%0d tc=%0b busy=%0b, need 0/0/0", Q, tc, busy);
    else n_pass++;
    // load_val == 0 while running
    load = 1'b1; load_val = 4'd4;
    step();
    load_val = 4'd0;
    step();
    load = 1'b0;
    n_checks++;
    if ({Q, tc, busy} !== {4'd0, 1'b0, 1'b0})
      $display("FAIL load_zero: Q=%0d tc=%0b busy=%0b, need 0/0/0", Q, tc, busy);
    else n_pass++;
    step();
    n_checks++;
    if ({Q, tc, busy} !== {4'd0, 1'b0, 1'b0})
      $display("FAIL load_zero_after: Q=%0d tc=%0b busy=%0b, need 0/0/0", Q, tc, busy);
    else n_pass++;
    // periodic reload of 1: tc on every enabled cycle
    load = 1'b1; load_val = 4'd1; auto_reload = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({Q, tc, busy} !== {4'd1, 1'b1, 1'b1})
        $display("FAIL period_one[%0d]: Q=%0d tc=%0b busy=%0b, need Q=1 tc=1 busy=1", i, Q, tc, busy);
      else n_pass++;
    end
    clear = 1'b1; auto_reload = 1'b0; en = 1'b0;
    step();
    clear = 1'b0;
  endtask

  task automatic test_async_reset();
    load = 1'b1; load_val = 4'd8; en = 1'b1;
    step();
    load = 1'b0;
    step();
    step();
    n_checks++;
    if ({Q, busy} !== {4'd6, 1'b1})
      $display("FAIL pre_reset: Q=%0d busy=%0b, need Q=6 busy=1", Q, busy);
    else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({Q, tc, busy} !== {4'd0, 1'b0, 1'b0})
      $display("FAIL async_reset: Q=%0d tc=%0b busy=%0b, need 0/0/0", Q, tc, busy);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({Q, tc, busy} !== {4'd0, 1'b0, 1'b0})
        $display("FAIL post_reset[%0d]: Q=%0d tc=%0b busy=%0b, need 0/0/0", i, Q, tc, busy);
      else n_pass++;
    end
    load = 1'b1; load_val = 4'd3;
    step();
    load = 1'b0;
    n_checks++;
    if ({Q, busy} !== {4'd3, 1'b1})
      $display("FAIL reload_after_reset: Q=%0d busy=%0b, need Q=3 busy=1", Q, busy);
    else n_pass++;
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_periodic();
    test_enable_gating_max();
    test_collisions();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
